// File: rtl/hamming_frame_serializer.sv
// -----------------------------------------------------------------------------
// hamming_frame_serializer
//
// Takes one 12-bit Hamming codeword per valid/ready handshake and sends it on a
// serial baseband line as a 14-bit frame. The frame is a start bit (0), then
// cw[11] down to cw[0], then a stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
// The line idles at mark (1).
//
// Parameters
//   CLKS_PER_BIT : clocks per bit period (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cw_in      in   [11:0] codeword; bit 11 is Hamming position 1
//   cw_valid   in   cw_in valid this cycle
//   cw_ready   out  block can accept a codeword (registered, IDLE only)
//   bit_out    out  serial line bit (registered)
//   bit_strobe out  one-cycle pulse in the first cycle of every bit period
//   busy       out  high while a frame is on the line
//   frame_done out  one-cycle pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module hamming_frame_serializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cw_in,
    input  logic        cw_valid,
    output logic        cw_ready,
    output logic        bit_out,
    output logic        bit_strobe,
    output logic        busy,
    output logic        frame_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [BW-1:0] baud_r, baud_s;
    logic [3:0]    idx_r, idx_s;
    logic [11:0]   shreg_r, shreg_s;
    logic          baud_end_s;

    logic          cw_ready_r, cw_ready_s;
    logic          bit_out_r, bit_out_s;
    logic          bit_strobe_r, bit_strobe_s;
    logic          busy_r, busy_s;
    logic          frame_done_r, frame_done_s;

    assign cw_ready   = cw_ready_r;
    assign bit_out    = bit_out_r;
    assign bit_strobe = bit_strobe_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        idx_s      = idx_r;
        shreg_s    = shreg_r;
        baud_end_s = (baud_r == BAUD_LAST);

        case (state_r)
            ST_IDLE: begin
                if (cw_valid && cw_ready_r) begin
                    state_s = ST_START;
                    baud_s  = '0;
                    idx_s   = 4'd0;
                    shreg_s = cw_in;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s = ST_DATA;
                    baud_s  = '0;
                    idx_s   = 4'd0;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (idx_r == 4'd11) begin
                        state_s = ST_STOP;
                        idx_s   = 4'd0;
                    end else begin
                        // The next data bit is always presented at shreg[11].
                        idx_s   = idx_r + 4'd1;
                        shreg_s = {shreg_r[10:0], 1'b0};
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    state_s = ST_IDLE;
                    baud_s  = '0;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = '0;
                idx_s   = 4'd0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        bit_out_s = 1'b1;
        case (state_s)
            ST_IDLE:  bit_out_s = 1'b1;
            ST_START: bit_out_s = 1'b0;
            ST_DATA:  bit_out_s = shreg_s[11];
            ST_STOP:  bit_out_s = 1'b1;
            default:  bit_out_s = 1'b1;
        endcase
        busy_s       = (state_s != ST_IDLE);
        cw_ready_s   = (state_s == ST_IDLE);
        bit_strobe_s = busy_s && (baud_s == '0);
        // With one clock per bit this fires on the stop-bit strobe cycle.
        frame_done_s = (state_s == ST_STOP) && (baud_s == BAUD_LAST);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            baud_r       <= '0;
            idx_r        <= 4'd0;
            shreg_r      <= 12'd0;
            cw_ready_r   <= 1'b0;
            bit_out_r    <= 1'b1;
            bit_strobe_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            baud_r       <= baud_s;
            idx_r        <= idx_s;
            shreg_r      <= shreg_s;
            cw_ready_r   <= cw_ready_s;
            bit_out_r    <= bit_out_s;
            bit_strobe_r <= bit_strobe_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

endmodule

// File: tb/tb_hamming_frame_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for hamming_frame_serializer. Two instances: one with four clocks
// per bit and one with a single clock per bit. A frame-level model predicts
// every output on every cycle. Directed frames are also compared against
// hand-computed line patterns and timings.
// -----------------------------------------------------------------------------
module tb_hamming_frame_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cw_in [2];
    logic        cw_valid [2];
    logic        ready [2];
    logic        bo [2];
    logic        strobe [2];
    logic        busy [2];
    logic        done [2];

    int checks = 0;
    int failures = 0;

    int          cpb [2] = '{4, 1};
    int          mt [2] = '{0, 0};
    logic [11:0] mcw [2] = '{12'd0, 12'd0};
    logic        mready [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    hamming_frame_serializer #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cw_in(cw_in[0]), .cw_valid(cw_valid[0]),
        .cw_ready(ready[0]), .bit_out(bo[0]), .bit_strobe(strobe[0]),
        .busy(busy[0]), .frame_done(done[0])
    );

    hamming_frame_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cw_in(cw_in[1]), .cw_valid(cw_valid[1]),
        .cw_ready(ready[1]), .bit_out(bo[1]), .bit_strobe(strobe[1]),
        .busy(busy[1]), .frame_done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: mt is the cycle number within the frame (0 = not framing).
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mt[i] = 0;
                mready[i] = 1'b0;
            end else if (mt[i] == 0) begin
                if (mready[i] && cw_valid[i]) begin
                    mt[i] = 1;
                    mcw[i] = cw_in[i];
                    mready[i] = 1'b0;
                end else begin
                    mready[i] = 1'b1;
                end
            end else if (mt[i] == 14 * cpb[i]) begin
                mt[i] = 0;
                mready[i] = 1'b1;
            end else begin
                mt[i] = mt[i] + 1;
            end
        end
    end

    function automatic logic exp_bit(input int i);
        int j;
        if (mt[i] == 0) return 1'b1;
        j = (mt[i] - 1) / cpb[i];
        if (j == 0) return 1'b0;
        if (j == 13) return 1'b1;
        return mcw[i][12 - j];
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bit_out[%0d]", i), bo[i], exp_bit(i));
            chk($sformatf("bit_strobe[%0d]", i), strobe[i],
                (mt[i] != 0) && ((mt[i] - 1) % cpb[i] == 0));
            chk($sformatf("frame_done[%0d]", i), done[i], mt[i] == 14 * cpb[i]);
            chk($sformatf("busy[%0d]", i), busy[i], mt[i] != 0);
            chk($sformatf("cw_ready[%0d]", i), ready[i], mready[i]);
        end
    end

    // Samples n negedges starting at the current one (t = 1).
    task automatic capture(input int i, input int n, output logic [13:0] bits,
                           output int ns, output int done_t, output int rdy_t);
        bits = 14'd0; ns = 0; done_t = -1; rdy_t = -1;
        for (int t = 1; t <= n; t++) begin
            if (strobe[i]) begin
                if (ns < 14) bits[13 - ns] = bo[i];
                ns++;
            end
            if (done[i] && done_t < 0) done_t = t;
            if (ready[i] && rdy_t < 0) rdy_t = t;
            if (t < n) @(negedge clk);
        end
    endtask

    // Waits (bounded) for ready, offers one codeword, returns at t = 1.
    task automatic send(input int i, input logic [11:0] cw);
        for (int k = 0; k < 100 && !ready[i]; k++) @(negedge clk);
        chk("send_ready", ready[i], 1'b1);
        cw_in[i] = cw;
        cw_valid[i] = 1'b1;
        @(negedge clk);
        cw_valid[i] = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [13:0] bits, input int ns,
                               input int done_t, input int rdy_t, input logic [13:0] exp_bits,
                               input int c);
        chk({name, "_bits"}, bits, exp_bits);
        chk({name, "_strobes"}, ns, 14);
        chk({name, "_done_t"}, done_t, 14 * c);
        chk({name, "_ready_t"}, rdy_t, 14 * c + 1);
    endtask

    initial begin
        logic [13:0] bits;
        int ns, dt, rt;

        cw_in[0] = 12'hE45; cw_valid[0] = 1'b1;
        cw_in[1] = 12'h000; cw_valid[1] = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held with cw_valid high.
        repeat (3) @(negedge clk);
        chk("rst_ready", ready[0], 1'b0);
        chk("rst_bit_out", bo[0], 1'b1);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_strobe", strobe[0], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", ready[0], 1'b1);

        // Single frame E45, accepted on the next edge; input then changes.
        @(negedge clk);
        cw_valid[0] = 1'b0;
        cw_in[0] = 12'hFFF;
        capture(0, 57, bits, ns, dt, rt);
        check_frame("e45", bits, ns, dt, rt, 14'b01110010001011, 4);

        // Back-to-back 000 then FFF with cw_valid held high.
        cw_in[0] = 12'h000; cw_valid[0] = 1'b1;
        @(negedge clk);
        cw_in[0] = 12'hFFF;
        capture(0, 57, bits, ns, dt, rt);
        check_frame("b2b0", bits, ns, dt, rt, 14'b00000000000001, 4);
        chk("b2b_gap_mark", bo[0], 1'b1);
        @(negedge clk);
        chk("b2b_start_bit", bo[0], 1'b0);
        chk("b2b_start_strobe", strobe[0], 1'b1);
        cw_valid[0] = 1'b0;
        capture(0, 57, bits, ns, dt, rt);
        check_frame("b2b1", bits, ns, dt, rt, 14'b01111111111111, 4);

        // Busy-time noise on cw_valid/cw_in during frame 5A3.
        cw_in[0] = 12'h5A3; cw_valid[0] = 1'b1;
        @(negedge clk);
        fork
            capture(0, 57, bits, ns, dt, rt);
            begin
                for (int t = 1; t <= 56; t++) begin
                    cw_in[0] = 12'hFFF;
                    cw_valid[0] = (t < 56) ? logic'(t % 2) : 1'b0;
                    if (t < 56) @(negedge clk);
                end
            end
        join
        check_frame("noise", bits, ns, dt, rt, 14'b00101101000111, 4);
        repeat (3) @(negedge clk);
        chk("noise_no_extra_accept", busy[0], 1'b0);

        // Reset during data bit 5 (t = 25..28) of frame A35; cw[6] = 0 there.
        send(0, 12'hA35);
        repeat (25) @(negedge clk);
        chk("mid_bit_before_rst", bo[0], 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bit_out", bo[0], 1'b1);
        chk("async_busy", busy[0], 1'b0);
        chk("async_ready", ready[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 12'h0F0);
        capture(0, 57, bits, ns, dt, rt);
        check_frame("after_rst", bits, ns, dt, rt, 14'b00000111100001, 4);

        // One clock per bit.
        send(1, 12'h801);
        capture(1, 15, bits, ns, dt, rt);
        check_frame("c1", bits, ns, dt, rt, 14'b01000000000011, 1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
